// File: rtl/pll_reconfig_ctrl_if.sv
// Divider-set offer handshake between a configuration source and pll_reconfig_ctrl.
interface pll_reconfig_ctrl_if;
    logic       cfg_valid;
    logic [5:0] cfg_idsel;
    logic [5:0] cfg_fbdsel;
    logic [5:0] cfg_odsel;
    logic       cfg_ready;

    modport master (
        output cfg_valid, cfg_idsel, cfg_fbdsel, cfg_odsel,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_idsel, cfg_fbdsel, cfg_odsel,
        output cfg_ready
    );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// PLL reset/lock sequencer: holds the PLL in reset, qualifies LOCK, retries on timeout
// and applies new divider sets offered over the cfg handshake.
module pll_reconfig_ctrl #(
    parameter logic [5:0]  IDIV_DEFAULT        = 6'd0,
    parameter logic [5:0]  FBDIV_DEFAULT       = 6'd0,
    parameter logic [5:0]  ODIV_DEFAULT        = 6'd8,
    parameter int unsigned RESET_HOLD_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic                      clkin,
    input  logic                      reset,
    input  logic                      pll_lock,
    pll_reconfig_ctrl_if.slave        cfg,
    output logic                      pll_reset,
    output logic [5:0]                pll_idsel,
    output logic [5:0]                pll_fbdsel,
    output logic [5:0]                pll_odsel,
    output logic                      locked,
    output logic                      busy,
    output logic                      error,
    output logic [7:0]                loss_cnt
);

    localparam int unsigned HoldW    = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int unsigned StableW  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned TimeoutW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int unsigned RetryW   = $clog2(MAX_RETRIES + 2);

    localparam logic [HoldW-1:0]    HoldLast    = HoldW'(RESET_HOLD_CYCLES - 1);
    localparam logic [StableW-1:0]  StableDone  = StableW'(LOCK_STABLE_CYCLES);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RetryW-1:0]   RetryMax    = RetryW'(MAX_RETRIES);

    typedef enum logic [1:0] {StHold, StWait, StRun, StFail} state_e;

    state_e              state_q, state_d;
    logic [1:0]          sync_q;
    logic                lock_s;
    logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [StableW-1:0]  stable_cnt_q, stable_cnt_d;
    logic [TimeoutW-1:0] timeout_cnt_q, timeout_cnt_d;
    logic [RetryW-1:0]   retry_cnt_q, retry_cnt_d;
    logic [7:0]          loss_cnt_q, loss_cnt_d;
    logic [5:0]          idsel_q, fbdsel_q, odsel_q;
    logic                cfg_ready_w;
    logic                accept;
    logic                load_cfg;

    assign lock_s      = sync_q[1];
    assign cfg_ready_w = (state_q == StRun) || (state_q == StFail);
    assign cfg.cfg_ready = cfg_ready_w;
    assign accept      = cfg.cfg_valid && cfg_ready_w;

    // LOCK means nothing while the PLL sits in reset, so the synchronizer is flushed
    // there; every attempt then sees the full two-stage latency.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else if (pll_reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q       <= StHold;
            hold_cnt_q    <= '0;
            stable_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            retry_cnt_q   <= '0;
            loss_cnt_q    <= '0;
            idsel_q       <= IDIV_DEFAULT;
            fbdsel_q      <= FBDIV_DEFAULT;
            odsel_q       <= ODIV_DEFAULT;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            stable_cnt_q  <= stable_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            retry_cnt_q   <= retry_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
            if (load_cfg) begin
                idsel_q  <= cfg.cfg_idsel;
                fbdsel_q <= cfg.cfg_fbdsel;
                odsel_q  <= cfg.cfg_odsel;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        stable_cnt_d  = stable_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        retry_cnt_d   = retry_cnt_q;
        loss_cnt_d    = loss_cnt_q;
        load_cfg      = 1'b0;

        unique case (state_q)
            StHold: begin
                if (hold_cnt_q == HoldLast) begin
                    state_d       = StWait;
                    hold_cnt_d    = '0;
                    stable_cnt_d  = '0;
                    timeout_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end
            end
            StWait: begin
                if (stable_cnt_q == StableDone) begin
                    state_d     = StRun;
                    retry_cnt_d = '0;
                end else if (timeout_cnt_q == TimeoutLast) begin
                    if (retry_cnt_q < RetryMax) begin
                        retry_cnt_d = retry_cnt_q + RetryW'(1);
                        state_d     = StHold;
                        hold_cnt_d  = '0;
                    end else begin
                        state_d = StFail;
                    end
                end else begin
                    // Timeout keeps running across lock glitches; only the streak restarts.
                    timeout_cnt_d = timeout_cnt_q + TimeoutW'(1);
                    stable_cnt_d  = lock_s ? stable_cnt_q + StableW'(1) : '0;
                end
            end
            StRun: begin
                if (accept) begin
                    state_d     = StHold;
                    hold_cnt_d  = '0;
                    retry_cnt_d = '0;
                    load_cfg    = 1'b1;
                end else if (!lock_s) begin
                    state_d       = StWait;
                    stable_cnt_d  = '0;
                    timeout_cnt_d = '0;
                    if (loss_cnt_q != 8'hff) begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end
                end
            end
            StFail: begin
                if (accept) begin
                    state_d     = StHold;
                    hold_cnt_d  = '0;
                    retry_cnt_d = '0;
                    load_cfg    = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        pll_reset = (state_q == StHold) || (state_q == StFail);
        locked    = (state_q == StRun);
        busy      = (state_q == StHold) || (state_q == StWait);
        error     = (state_q == StFail);
    end

    assign pll_idsel  = idsel_q;
    assign pll_fbdsel = fbdsel_q;
    assign pll_odsel  = odsel_q;
    assign loss_cnt   = loss_cnt_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed and randomized bench for pll_reconfig_ctrl against a cycle-level reference model.
module tb_pll_reconfig_ctrl;

    localparam int HOLD_CYC    = 4;
    localparam int STABLE_CYC  = 8;
    localparam int TIMEOUT_CYC = 64;
    localparam int RETRIES     = 2;

    localparam int PH_HOLD = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_FAIL = 3;

    logic       clkin    = 1'b0;
    logic       reset    = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset, locked, busy, error;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic [7:0] loss_cnt;

    pll_reconfig_ctrl_if cfg_if ();

    pll_reconfig_ctrl #(
        .IDIV_DEFAULT        (6'd0),
        .FBDIV_DEFAULT       (6'd0),
        .ODIV_DEFAULT        (6'd8),
        .RESET_HOLD_CYCLES   (HOLD_CYC),
        .LOCK_STABLE_CYCLES  (STABLE_CYC),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT_CYC),
        .MAX_RETRIES         (RETRIES)
    ) dut (
        .clkin      (clkin),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .cfg        (cfg_if),
        .pll_reset  (pll_reset),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .locked     (locked),
        .busy       (busy),
        .error      (error),
        .loss_cnt   (loss_cnt)
    );

    always #5 clkin = ~clkin;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Reference model: phase, lock history and elapsed-cycle bookkeeping.
    bit         m_s1, m_s2;
    int         m_ph, m_hold, m_stable, m_age, m_tries, m_loss;
    logic [5:0] m_id, m_fb, m_od;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    task automatic model_reset();
        m_ph = PH_HOLD; m_s1 = 0; m_s2 = 0;
        m_hold = 0; m_stable = 0; m_age = 0; m_tries = 0; m_loss = 0;
        m_id = 6'd0; m_fb = 6'd0; m_od = 6'd8;
    endtask

    task automatic take_cfg();
        m_ph = PH_HOLD; m_hold = 0; m_tries = 0;
        m_id = cfg_if.cfg_idsel; m_fb = cfg_if.cfg_fbdsel; m_od = cfg_if.cfg_odsel;
    endtask

    task automatic model_edge();
        bit ls, acc;
        int ph0;
        ls  = m_s2;
        ph0 = m_ph;
        acc = cfg_if.cfg_valid && (ph0 == PH_RUN || ph0 == PH_FAIL);
        if (ph0 == PH_HOLD || ph0 == PH_FAIL) begin
            m_s1 = 0; m_s2 = 0;
        end else begin
            m_s2 = m_s1; m_s1 = pll_lock;
        end
        case (ph0)
            PH_HOLD: begin
                m_hold++;
                if (m_hold == HOLD_CYC) begin
                    m_ph = PH_WAIT; m_stable = 0; m_age = 0;
                end
            end
            PH_WAIT: begin
                if (m_stable == STABLE_CYC) begin
                    m_ph = PH_RUN; m_tries = 0;
                end else begin
                    m_age++;
                    if (m_age == TIMEOUT_CYC) begin
                        if (m_tries < RETRIES) begin
                            m_tries++; m_ph = PH_HOLD; m_hold = 0;
                        end else begin
                            m_ph = PH_FAIL;
                        end
                    end else begin
                        m_stable = ls ? m_stable + 1 : 0;
                    end
                end
            end
            PH_RUN: begin
                if (acc) take_cfg();
                else if (!ls) begin
                    m_ph = PH_WAIT; m_stable = 0; m_age = 0;
                    if (m_loss < 255) m_loss++;
                end
            end
            default: if (acc) take_cfg();
        endcase
    endtask

    task automatic check_all();
        check("pll_reset", pll_reset, m_ph == PH_HOLD || m_ph == PH_FAIL);
        check("locked", locked, m_ph == PH_RUN);
        check("busy", busy, m_ph == PH_HOLD || m_ph == PH_WAIT);
        check("error", error, m_ph == PH_FAIL);
        check("cfg_ready", cfg_if.cfg_ready, m_ph == PH_RUN || m_ph == PH_FAIL);
        check("pll_idsel", pll_idsel, m_id);
        check("pll_fbdsel", pll_fbdsel, m_fb);
        check("pll_odsel", pll_odsel, m_od);
        check("loss_cnt", loss_cnt, m_loss);
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
        if (reset) model_reset();
        else model_edge();
        cyc++;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_locked(input int max_cyc, input string tag, output int n);
        n = 0;
        while (locked !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        check(tag, locked, 1'b1);
    endtask

    task automatic wait_phase(input int ph, input int max_cyc, input string tag);
        int n;
        n = 0;
        while (m_ph != ph && n < max_cyc) begin
            step();
            n++;
        end
        check(tag, m_ph, ph);
    endtask

    task automatic offer(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_idsel  = a;
        cfg_if.cfg_fbdsel = b;
        cfg_if.cfg_odsel  = c;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        int         n, falls, loss0;
        logic       prev;
        logic [5:0] ra, rb, rc;

        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_idsel  = 6'd0;
        cfg_if.cfg_fbdsel = 6'd0;
        cfg_if.cfg_odsel  = 6'd0;
        step();
        step();

        // Power-up with LOCK constantly high.
        pll_lock = 1'b1;
        reset    = 1'b0;
        n = 0;
        while (pll_reset === 1'b1 && n < 50) begin step(); n++; end
        check("hold_len", n, HOLD_CYC);
        wait_locked(100, "first_lock", n);
        check("first_lock_latency", n, 11);
        check("default_sels", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd0, 6'd0, 6'd8});

        // Single-cycle LOCK glitch during WAIT restarts the stable streak.
        do_reset();
        wait_phase(PH_WAIT, 20, "glitch_wait_entry");
        repeat (5) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        n = 6;
        while (locked !== 1'b1 && n < 100) begin step(); n++; end
        check("glitch_latency", n, 17);
        check("glitch_no_error", error, 1'b0);

        // No lock at all: three attempts, then FAIL.
        do_reset();
        pll_lock = 1'b0;
        falls = 0;
        prev  = pll_reset;
        n     = 0;
        while (error !== 1'b1 && n < 400) begin
            step();
            if (prev === 1'b1 && pll_reset === 1'b0) falls++;
            prev = pll_reset;
            n++;
        end
        check("attempts", falls, 3);
        check("fail_latency", n, 3 * (HOLD_CYC + TIMEOUT_CYC));
        check("fail_ready", cfg_if.cfg_ready, 1'b1);
        check("fail_busy", busy, 1'b0);
        repeat (10) begin pll_lock = 1'($urandom); step(); end

        // Exit FAIL by a random config; offers while not ready are dropped.
        pll_lock = 1'b1;
        ra = 6'($urandom); rb = 6'($urandom); rc = 6'($urandom);
        offer(ra, rb, rc);
        check("fail_exit_sels", {pll_idsel, pll_fbdsel, pll_odsel}, {ra, rb, rc});
        repeat (3) begin
            cfg_if.cfg_valid  = 1'b1;
            cfg_if.cfg_idsel  = ~ra;
            cfg_if.cfg_fbdsel = ~rb;
            cfg_if.cfg_odsel  = ~rc;
            step();
        end
        cfg_if.cfg_valid = 1'b0;
        check("ignored_sels", {pll_idsel, pll_fbdsel, pll_odsel}, {ra, rb, rc});
        wait_locked(100, "fail_relock", n);

        // Reconfigure from RUN.
        offer(6'd2, 6'd5, 6'd4);
        check("reconf_sels", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd2, 6'd5, 6'd4});
        check("reconf_reset", pll_reset, 1'b1);
        check("reconf_unlocked", locked, 1'b0);
        n = 0;
        while (pll_reset === 1'b1 && n < 20) begin step(); n++; end
        check("reconf_hold", n, HOLD_CYC);
        wait_locked(100, "reconf_lock", n);
        check("reconf_lock_latency", n, 11);

        // Accept coinciding with synced lock loss: accept wins, no loss counted.
        loss0 = m_loss;
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        step();
        offer(6'd7, 6'd9, 6'd11);
        check("race_loss", loss_cnt, loss0);
        check("race_reset", pll_reset, 1'b1);
        check("race_sels", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd7, 6'd9, 6'd11});
        wait_locked(100, "race_relock", n);

        // One-cycle drop in RUN.
        loss0 = m_loss;
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        n = 1;
        while (locked === 1'b1 && n < 10) begin step(); n++; end
        check("loss_latency", n, 3);
        check("loss_inc", loss_cnt, loss0 + 1);
        wait_locked(100, "loss_relock", n);
        check("loss_relock_latency", n, STABLE_CYC + 1);

        // Randomized mix of glitchy lock and sporadic offers.
        repeat (2500) begin
            pll_lock          = ($urandom_range(0, 15) != 0);
            cfg_if.cfg_valid  = ($urandom_range(0, 63) == 0);
            cfg_if.cfg_idsel  = 6'($urandom);
            cfg_if.cfg_fbdsel = 6'($urandom);
            cfg_if.cfg_odsel  = 6'($urandom);
            step();
        end
        cfg_if.cfg_valid = 1'b0;

        // Loss counter saturation.
        do_reset();
        pll_lock = 1'b1;
        wait_locked(100, "sat_lock", n);
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            step();
            pll_lock = 1'b1;
            repeat (2) step();
            n = 0;
            while (locked !== 1'b1 && n < 30) begin step(); n++; end
        end
        check("loss_saturated", loss_cnt, 8'd255);

        // Asynchronous reset mid-WAIT after a reconfiguration.
        do_reset();
        wait_locked(100, "areset_lock", n);
        offer(6'd2, 6'd5, 6'd4);
        wait_phase(PH_WAIT, 20, "areset_wait_entry");
        repeat (3) step();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("areset_sels", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd0, 6'd0, 6'd8});
        check("areset_locked", locked, 1'b0);
        check("areset_pll_reset", pll_reset, 1'b1);
        check_all();
        step();
        reset = 1'b0;
        wait_locked(100, "areset_relock", n);
        check("areset_relock_latency", n, HOLD_CYC + 11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
